// File: rtl/tdc_meas_sequencer_pkg.sv
// Shared types and widths for the TDC measurement sequencer.
// Defining TDC_EPOCH_EN widens each result by a 16-bit epoch field.
`ifndef TDC_SEQ_DATA_W
`define TDC_SEQ_DATA_W(w) ((w) + tdc_meas_sequencer_pkg::EXT_W)
`endif

package tdc_meas_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_WAIT,
    S_CAPTURE,
    S_HOLDOFF
  } state_t;

  localparam int EPOCH_W = 16;
  localparam int DROP_W  = 8;

`ifdef TDC_EPOCH_EN
  localparam int EXT_W = EPOCH_W;
`else
  localparam int EXT_W = 0;
`endif

  function automatic int max3(
    input int a,
    input int b,
    input int c
  );
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

  function automatic logic [DROP_W-1:0] sat_inc(
    input logic [DROP_W-1:0] v
  );
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/tdc_stream_if.sv
// Result stream from the sequencer FIFO to the readout logic.
// Plain valid/ready handshake; a word moves when oValid && iReady.
interface tdc_stream_if #(
  parameter int W = 16
);
  logic [W-1:0] oData;
  logic         oValid;
  logic         iReady;

  modport master (
    output oData,
    output oValid,
    input  iReady
  );

  modport slave (
    input  oData,
    input  oValid,
    output iReady
  );
endinterface

// File: rtl/tdc_result_fifo.sv
// First-word-fall-through synchronous FIFO for TDC results.
// A push into a full FIFO is accepted only alongside a pop.
module tdc_result_fifo #(
  parameter int  W     = 16,
  parameter int  DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic          full,
  output logic          empty,
  output logic [LW-1:0] level
);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty   = (level == '0);
  assign full    = (level == LW'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      level <= level + LW'(do_push) - LW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/tdc_meas_sequencer.sv
// Arms the delay-line TDC, waits for done with timeout, queues results.
// Build with TDC_EPOCH_EN to tag each result with a 16-bit epoch.
module tdc_meas_sequencer
  import tdc_meas_sequencer_pkg::*;
#(
  parameter int  TDC_W       = 16,
  parameter int  FIFO_DEPTH  = 8,
  parameter int  ARM_CYC     = 4,
  parameter int  TIMEOUT_CYC = 1023,
  parameter int  HOLDOFF_CYC = 2,
  localparam int LVL_W  = $clog2(FIFO_DEPTH) + 1,
  localparam int DATA_W = `TDC_SEQ_DATA_W(TDC_W)
) (
  input  logic              iClk,
  input  logic              iRst_n,
  input  logic              iEnable,
  input  logic              iSingle,
  output logic              oTdcRst,
  input  logic              iTdcDone,
  input  logic [TDC_W-1:0]  iTdcData,
  tdc_stream_if.master      rd,
  output logic              oBusy,
  output logic              oTimeout,
  output logic [DROP_W-1:0] oDropCnt,
  output logic [LVL_W-1:0]  oLevel
);

  localparam int CNT_MAX =
    max3(ARM_CYC, TIMEOUT_CYC, HOLDOFF_CYC);
  localparam int CNT_W = $clog2(CNT_MAX + 1);

  state_t              state;
  state_t              state_n;
  logic [CNT_W-1:0]    cnt;
  logic [CNT_W-1:0]    cnt_n;
  logic                single;
  logic                single_n;
  logic                timeout_n;
  logic                cap_load;
  logic [DATA_W-1:0]   cap_word;
  logic [DATA_W-1:0]   cap_next;
  logic                fifo_full;
  logic                fifo_empty;
  logic                push;
  logic                drop;

`ifdef TDC_EPOCH_EN
  logic [EPOCH_W-1:0] epoch;

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) epoch <= '0;
    else         epoch <= epoch + 1'b1;
  end

  assign cap_next = {epoch, iTdcData};
`else
  assign cap_next = iTdcData;
`endif

  always_comb begin
    state_n   = state;
    cnt_n     = cnt + 1'b1;
    single_n  = single;
    timeout_n = 1'b0;
    cap_load  = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (iEnable) begin
          state_n = S_ARM;
        end else if (iSingle) begin
          state_n  = S_ARM;
          single_n = 1'b1;
        end
      end
      S_ARM: begin
        if (cnt == CNT_W'(ARM_CYC - 1))
          state_n = S_WAIT;
      end
      S_WAIT: begin
        if (iTdcDone) begin
          state_n  = S_CAPTURE;
          cap_load = 1'b1;
        end else if (cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
          timeout_n = 1'b1;
          single_n  = 1'b0;
          state_n   = iEnable ? S_ARM : S_IDLE;
        end else if (!iEnable && !single) begin
          state_n = S_IDLE;
        end
      end
      S_CAPTURE: begin
        // A single shot skips the dead time.
        if (HOLDOFF_CYC == 0 || single) begin
          single_n = 1'b0;
          state_n  = iEnable ? S_ARM : S_IDLE;
        end else begin
          state_n = S_HOLDOFF;
        end
      end
      S_HOLDOFF: begin
        if (cnt == CNT_W'(HOLDOFF_CYC - 1)) begin
          single_n = 1'b0;
          state_n  = iEnable ? S_ARM : S_IDLE;
        end
      end
      default: begin
        state_n  = S_IDLE;
        single_n = 1'b0;
      end
    endcase
    if (state_n != state || state == S_IDLE)
      cnt_n = '0;
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state    <= S_IDLE;
      cnt      <= '0;
      single   <= 1'b0;
      oTdcRst  <= 1'b1;
      oBusy    <= 1'b0;
      oTimeout <= 1'b0;
      oDropCnt <= '0;
      cap_word <= '0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      single   <= single_n;
      oTdcRst  <= (state_n != S_WAIT);
      oBusy    <= (state_n != S_IDLE);
      oTimeout <= timeout_n;
      if (cap_load) cap_word <= cap_next;
      if (drop)     oDropCnt <= sat_inc(oDropCnt);
    end
  end

  assign push = (state == S_CAPTURE);
  assign drop = push && fifo_full && !rd.iReady;

  tdc_result_fifo #(
    .W     (DATA_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (iClk),
    .rst_n (iRst_n),
    .push  (push),
    .pop   (rd.iReady),
    .din   (cap_word),
    .dout  (rd.oData),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (oLevel)
  );

  assign rd.oValid = !fifo_empty;

endmodule
